// File: rtl/bcd_chain_timer.sv
// bcd_chain_timer: chain of per-digit counters with ripple borrow/carry.
// Each digit counts 0..its own max, so mixed-radix displays (e.g. MM:SS)
// are supported. Advances once per rising edge of step, with direction
// select, clamped parallel load, and saturate-or-wrap at the terminal count.
module bcd_chain_timer #(
  parameter int NUM_DIGITS = 4,
  parameter int DIGIT_W    = 4,
  parameter logic [NUM_DIGITS*DIGIT_W-1:0] MAX_DIGITS = 16'h5959
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          step,
  input  logic                          up,
  input  logic                          wrap_en,
  input  logic                          load,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] load_value,
  output logic [NUM_DIGITS*DIGIT_W-1:0] count_out,
  output logic                          done,
  output logic                          expired,
  output logic                          carry_out
);

  localparam int TOTAL_W = NUM_DIGITS * DIGIT_W;

  logic [TOTAL_W-1:0]  r_count;
  logic                r_step_q;
  logic                r_expired;
  logic                r_carry_out;

  logic [TOTAL_W-1:0]  w_next;        // count after one step (ripple result)
  logic [TOTAL_W-1:0]  w_load_clamped;
  logic [TOTAL_W-1:0]  w_terminal;
  logic [NUM_DIGITS:0] w_ripple;      // borrow (down) or carry (up) into each digit
  logic                w_edge;
  logic                w_next_terminal;

  assign w_edge      = step & ~r_step_q;
  assign w_ripple[0] = 1'b1;

  // Terminal value follows the current direction, so done reacts to up at once.
  assign w_terminal      = up ? MAX_DIGITS : '0;
  assign done            = (r_count == w_terminal);
  assign w_next_terminal = (w_next == w_terminal);

  // Per-digit step and load logic. A digit at its end (0 going down, max going
  // up) reloads the opposite end and passes the ripple on; a digit with max 0
  // is always at its end, so it stays 0 and passes the ripple straight through.
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    logic [DIGIT_W-1:0] w_cur;
    logic [DIGIT_W-1:0] w_max;
    logic [DIGIT_W-1:0] w_ld;
    logic               w_at_end;

    assign w_cur    = r_count[i*DIGIT_W +: DIGIT_W];
    assign w_max    = MAX_DIGITS[i*DIGIT_W +: DIGIT_W];
    assign w_ld     = load_value[i*DIGIT_W +: DIGIT_W];
    assign w_at_end = up ? (w_cur >= w_max) : (w_cur == '0);

    assign w_next[i*DIGIT_W +: DIGIT_W] =
        !w_ripple[i] ? w_cur :
        w_at_end     ? (up ? '0 : w_max) :
        up           ? w_cur + DIGIT_W'(1) : w_cur - DIGIT_W'(1);

    assign w_ripple[i+1] = w_ripple[i] & w_at_end;

    assign w_load_clamped[i*DIGIT_W +: DIGIT_W] = (w_ld > w_max) ? w_max : w_ld;
  end

  // Count register, step edge history and one-cycle event pulses.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count     <= '0;
      r_step_q    <= 1'b0;
      r_expired   <= 1'b0;
      r_carry_out <= 1'b0;
    end else begin
      r_step_q    <= step;
      r_expired   <= 1'b0;
      r_carry_out <= 1'b0;
      if (load) begin
        r_count <= w_load_clamped;
      end else if (enable && w_edge) begin
        if (done) begin
          // At the terminal the ripple runs the full chain, so w_next is
          // already the opposite terminal.
          if (wrap_en) begin
            r_count     <= w_next;
            r_carry_out <= w_ripple[NUM_DIGITS];
          end
        end else begin
          r_count   <= w_next;
          r_expired <= w_next_terminal;
        end
      end
    end
  end

  assign count_out = r_count;
  assign expired   = r_expired;
  assign carry_out = r_carry_out;

endmodule

// File: doc/bcd_chain_timer.md
# bcd_chain_timer

Parametrised multi-digit countdown/count-up timer built from a chain of per-digit counters with ripple borrow/carry. Each digit has its own maximum value, so mixed-radix displays such as MM:SS are supported. Advances once per rising edge of `step`, supports direction select, clamped parallel load, and saturate-or-wrap at the terminal count. Sits between the tick/prescaler logic and the display/alarm logic in the timer subsystem.

## Interface
Parameters:
- `NUM_DIGITS`, 4: number of digits in the chain, minimum 1.
- `DIGIT_W`, 4: bits per digit.
- `MAX_DIGITS`, 16'h5959: packed per-digit maximum values, `NUM_DIGITS*DIGIT_W` bits wide. Digit 0 is the LSBs and the least significant digit.

Ports:
- `clk` in 1: clock. All state changes on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `enable` in 1: allows counting. When low, step edges are discarded.
- `step` in 1: count request. Acts on its rising edge only.
- `up` in 1: direction. 1 counts up, 0 counts down.
- `wrap_en` in 1: 1 wraps at the terminal count, 0 saturates there.
- `load` in 1: parallel load strobe.
- `load_value` in `NUM_DIGITS*DIGIT_W`: value to load, packed per digit.
- `count_out` out `NUM_DIGITS*DIGIT_W`: registered count, packed per digit.
- `done` out 1: combinational. High when `count_out` equals the terminal value for the current `up`.
- `expired` out 1: registered one-cycle pulse.
- `carry_out` out 1: registered one-cycle pulse for the whole-chain wrap.

## Operation
- Terminal value:
  - down mode: all digits 0.
  - up mode: every digit at its `MAX_DIGITS` value.
- Edge detect: `step_q` is a register loaded with `step` every cycle, regardless of `enable` or `load`. `edge = step & ~step_q`.
- Priority, highest first: `reset` > `load` > (`enable & edge`) > hold.
- Load: each digit gets min(`load_value` digit, its max), clamped independently. Example: 16'h7A9F loads as 16'h5959. Load never pulses `expired` or `carry_out`.
- Down step, ripple borrow from digit 0:
  - A digit at 0 with a borrow-in becomes its max and propagates the borrow.
  - Otherwise the digit decrements and the borrow stops.
- Up step, ripple carry from digit 0:
  - A digit at its max with a carry-in becomes 0 and propagates the carry.
  - Otherwise the digit increments and the carry stops.
- Step while `done`=1:
  - `wrap_en`=1: count becomes the opposite terminal (down → all max, up → all 0), and `carry_out` pulses.
  - `wrap_en`=0: count holds, no pulses.
- `expired` pulses when a step moves the count from non-terminal to terminal.
- A digit whose max is 0 is always 0 and passes borrow/carry straight through.
- Changing `up` mid-count takes effect on the next step. `done` re-evaluates combinationally on that change.

## Timing
- Reset values:
  - `count_out` = 0
  - `step_q` = 0
  - `expired` = 0
  - `carry_out` = 0
  - `done` then reads 1 in down mode.
- Reset mid-count clears everything on that edge. A step edge in the same cycle is lost.
- Step latency: `step` sampled high at edge N with `step_q`=0 updates `count_out` after edge N. `expired`/`carry_out` are high for exactly the cycle after edge N.
- `step` held high for any number of cycles produces exactly one count. It must be seen low for at least one clock before the next edge counts.
- `load` and a step edge in the same cycle: the load wins, the edge is consumed, and no second count occurs.
- A step edge while `enable`=0 is consumed. Raising `enable` later does not replay it.
- The worst-case ripple path spans all `NUM_DIGITS` digits within one cycle. There is no multi-cycle path.

## Test plan
All scenarios use the default parameters.
- Reset, load 16'h0130, down, one step pulse → 16'h0129. One more step → 16'h0128. `expired`=0 throughout.
- Load 16'h0100, down, step → 16'h0059 (the tens digit wraps to max 5). Load 16'h7A9F → 16'h5959 with no pulses.
- Load 16'h0001, down, `wrap_en`=0:
  - step → 16'h0000, `expired` one cycle, `done`=1.
  - step → still 16'h0000, no pulses.
  - set `wrap_en`=1, step → 16'h5959, `carry_out` one cycle.
- Load 16'h5958, `up`=1, step → 16'h5959, `expired` pulse, `done`=1. With `wrap_en`=1, step → 16'h0000 and `carry_out` pulse.
- Hold `step` high for 5 cycles → exactly one decrement.
  - Step edge with `enable`=0 → no change.
  - `load` together with a step edge → loaded value only.
- Mid-count at 16'h0042, assert `reset` together with a step edge → `count_out`=0, all pulses 0 the next cycle.
